wasm_alu_issue: RTL and testbench

Initiator side of the i32 ALU operation interface. Accepts one decoded i32 numeric opcode, pops operands from the value stack, issues the op to the i32 ALU, and pushes the result back. Sits between the execute-stage sequencer and the ALU/value stack. On an ALU trap it halts the core. Operand order follows the WebAssembly convention: top of stack is operand_b, next is operand_a.

---
 rtl/wasm_alu_issue.sv | 213 +++++++++++++++++++++
 tb/tb_wasm_alu_issue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_alu_issue.sv
// Initiator for the i32 ALU: pops operands from the value stack, issues one op,
// and pushes the result back or halts the core on an ALU trap.
package wasm_alu_pkg;
    typedef enum logic [4:0] {
        ALU_ADD = 5'd0, ALU_SUB, ALU_MUL, ALU_DIV_S, ALU_DIV_U, ALU_REM_S, ALU_REM_U,
        ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR_S, ALU_SHR_U, ALU_ROTL, ALU_ROTR,
        ALU_CLZ, ALU_CTZ, ALU_POPCNT, ALU_EQZ, ALU_EQ, ALU_NE, ALU_LT_S, ALU_LT_U,
        ALU_GT_S, ALU_GT_U, ALU_LE_S, ALU_LE_U, ALU_GE_S, ALU_GE_U
    } alu_op_t;

    typedef enum logic [1:0] {
        TRAP_NONE         = 2'd0,
        TRAP_INT_DIV_ZERO = 2'd1,
        TRAP_INT_OVERFLOW = 2'd2,
        TRAP_INVALID_OP   = 2'd3
    } trap_t;
endpackage

module wasm_alu_issue
    import wasm_alu_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  alu_op_t          cmd_op,
    output logic             pop_req,
    input  logic             pop_ack,
    input  logic             pop_empty,
    input  logic [31:0]      pop_data,
    output logic             push_valid,
    input  logic             push_ready,
    output logic [31:0]      push_data,
    output logic             alu_valid,
    output alu_op_t          alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic             alu_valid_out,
    input  logic [31:0]      alu_result,
    input  trap_t            alu_trap,
    output logic             trap_valid,
    output trap_t            trap_code,
    output logic             err_underflow,
    output logic             err_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam int TMR_W = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP_B = 3'd1,
        S_POP_A = 3'd2,
        S_EXEC  = 3'd3,
        S_PUSH  = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t           state_r, state_s;
    alu_op_t          op_r, op_s;
    logic             unary_r, unary_s;
    logic [31:0]      a_r, a_s, b_r, b_s;
    logic [TMR_W-1:0] tmr_r, tmr_s;
    trap_t            trap_code_s;
    logic             underflow_s, timeout_s, capture_s, push_fire_s;

    function automatic logic is_unary(input alu_op_t op);
        case (op)
            ALU_CLZ, ALU_CTZ, ALU_POPCNT, ALU_EQZ: is_unary = 1'b1;
            default:                              is_unary = 1'b0;
        endcase
    endfunction

    // Next-state and datapath-load decode.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        unary_s     = unary_r;
        a_s         = a_r;
        b_s         = b_r;
        tmr_s       = tmr_r;
        trap_code_s = trap_code;
        underflow_s = 1'b0;
        timeout_s   = 1'b0;
        capture_s   = 1'b0;
        push_fire_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                // cmd_ready (not just the state) gates acceptance so the
                // cycle right after reset, with all outputs low, ignores requests.
                if (cmd_ready && cmd_valid) begin
                    op_s    = cmd_op;
                    unary_s = is_unary(cmd_op);
                    state_s = S_POP_B;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_POP_B: begin
                if (pop_empty) begin
                    underflow_s = 1'b1;
                    state_s     = S_IDLE;
                end else if (pop_ack) begin
                    if (unary_r) begin
                        a_s     = pop_data;
                        b_s     = 32'd0;
                        tmr_s   = '0;
                        state_s = S_EXEC;
                    end else begin
                        b_s     = pop_data;
                        state_s = S_POP_A;
                    end
                end else begin
                    state_s = S_POP_B;
                end
            end
            S_POP_A: begin
                if (pop_empty) begin
                    underflow_s = 1'b1;
                    state_s     = S_IDLE;
                end else if (pop_ack) begin
                    a_s     = pop_data;
                    tmr_s   = '0;
                    state_s = S_EXEC;
                end else begin
                    state_s = S_POP_A;
                end
            end
            S_EXEC: begin
                if (alu_valid_out) begin
                    if (alu_trap == TRAP_NONE) begin
                        capture_s = 1'b1;
                        state_s   = S_PUSH;
                    end else begin
                        trap_code_s = alu_trap;
                        state_s     = S_HALT;
                    end
                end else if (tmr_r == TMR_W'(ALU_TIMEOUT - 1)) begin
                    timeout_s = 1'b1;
                    state_s   = S_IDLE;
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            S_PUSH: begin
                if (push_ready) begin
                    push_fire_s = 1'b1;
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_PUSH;
                end
            end
            S_HALT: state_s = S_HALT;
            default: state_s = S_IDLE;
        endcase
    end

    // State, operand registers and outputs registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            op_r          <= alu_op_t'(5'd0);
            unary_r       <= 1'b0;
            a_r           <= 32'd0;
            b_r           <= 32'd0;
            tmr_r         <= '0;
            cmd_ready     <= 1'b0;
            pop_req       <= 1'b0;
            push_valid    <= 1'b0;
            push_data     <= 32'd0;
            alu_valid     <= 1'b0;
            alu_op        <= alu_op_t'(5'd0);
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            trap_valid    <= 1'b0;
            trap_code     <= TRAP_NONE;
            err_underflow <= 1'b0;
            err_timeout   <= 1'b0;
            busy          <= 1'b0;
            ops_done      <= '0;
        end else begin
            state_r       <= state_s;
            op_r          <= op_s;
            unary_r       <= unary_s;
            a_r           <= a_s;
            b_r           <= b_s;
            tmr_r         <= tmr_s;
            cmd_ready     <= (state_s == S_IDLE);
            pop_req       <= (state_s == S_POP_B) || (state_s == S_POP_A);
            push_valid    <= (state_s == S_PUSH);
            alu_valid     <= (state_s == S_EXEC);
            alu_op        <= (state_s == S_EXEC) ? op_s : alu_op_t'(5'd0);
            alu_a         <= (state_s == S_EXEC) ? a_s : 32'd0;
            alu_b         <= (state_s == S_EXEC) ? b_s : 32'd0;
            trap_valid    <= (state_s == S_HALT);
            trap_code     <= trap_code_s;
            err_underflow <= underflow_s;
            err_timeout   <= timeout_s;
            busy          <= (state_s != S_IDLE);
            if (capture_s) begin
                push_data <= alu_result;
            end
            if (push_fire_s) begin
                ops_done <= ops_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wasm_alu_issue.sv
// Directed bench for wasm_alu_issue: value-stack and ALU responders live here,
// expected values are hand-computed constants.
module tb_wasm_alu_issue;
    import wasm_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    alu_op_t     cmd_op;
    logic        pop_req, pop_ack, pop_empty;
    logic [31:0] pop_data;
    logic        push_valid, push_ready;
    logic [31:0] push_data;
    logic        alu_valid;
    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b;
    logic        alu_valid_out;
    logic [31:0] alu_result;
    trap_t       alu_trap;
    logic        trap_valid;
    trap_t       trap_code;
    logic        err_underflow, err_timeout, busy;
    logic [31:0] ops_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] stk [0:7];
    int          depth = 0;
    int          pop_base = 0;
    int          avail;
    logic        alu_en = 1'b1;

    int          pop_cnt = 0;
    int          push_cnt = 0;
    int          alu_cyc = 0;
    int          uf_cyc = 0;
    int          to_cyc = 0;
    logic [31:0] last_push = 32'd0;
    logic [31:0] last_b = 32'd0;

    always #5 clk = ~clk;

    wasm_alu_issue #(.ALU_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .pop_req(pop_req), .pop_ack(pop_ack), .pop_empty(pop_empty), .pop_data(pop_data),
        .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_valid_out(alu_valid_out), .alu_result(alu_result), .alu_trap(alu_trap),
        .trap_valid(trap_valid), .trap_code(trap_code),
        .err_underflow(err_underflow), .err_timeout(err_timeout),
        .busy(busy), .ops_done(ops_done)
    );

    function automatic logic [31:0] ref_alu(input alu_op_t op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_LT_S:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_DIV_S: r = (b == 32'd0) ? 32'd0 : 32'($signed(a) / $signed(b));
            ALU_CLZ: begin
                r = 32'd32;
                for (int i = 0; i < 32; i++) if (a[i]) r = 32'(31 - i);
            end
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    // Stack responder: acks immediately while values remain.
    always_comb begin
        avail     = depth - (pop_cnt - pop_base);
        pop_empty = (avail <= 0);
        pop_ack   = pop_req && (avail > 0);
        pop_data  = (avail > 0) ? stk[avail-1] : 32'd0;
    end

    // Combinational ALU responder.
    always_comb begin
        alu_valid_out = alu_valid && alu_en;
        alu_result    = ref_alu(alu_op, alu_a, alu_b);
        alu_trap      = (alu_op == ALU_DIV_S && alu_b == 32'd0) ? TRAP_INT_DIV_ZERO : TRAP_NONE;
    end

    always @(posedge clk) begin
        if (pop_req && pop_ack) pop_cnt <= pop_cnt + 1;
        if (push_valid && push_ready) begin
            push_cnt  <= push_cnt + 1;
            last_push <= push_data;
        end
        if (alu_valid) begin
            alu_cyc <= alu_cyc + 1;
            last_b  <= alu_b;
        end
        if (err_underflow) uf_cyc <= uf_cyc + 1;
        if (err_timeout)   to_cyc <= to_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load2(input logic [31:0] a, input logic [31:0] b);
        stk[0]   = a;
        stk[1]   = b;
        depth    = 2;
        pop_base = pop_cnt;
    endtask

    task automatic issue(input alu_op_t op);
        int n;
        n = 0;
        while (!cmd_ready && n < 10) begin
            tick();
            n++;
        end
        check("issue_ready", 32'(cmd_ready), 32'd1);
        cmd_op    = op;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!cmd_ready && !trap_valid && n < limit) begin
            tick();
            n++;
        end
        if (!cmd_ready && !trap_valid) check("wait_bound", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input alu_op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_ops);
        load2(a, b);
        issue(op);
        wait_idle(40);
        tick();
        check({tag, "_push"}, last_push, ref_alu(op, a, b));
        check({tag, "_ops"}, ops_done, exp_ops);
    endtask

    initial begin
        int ops0, pc0, uf0, to0, al0, p0, bad, n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = ALU_ADD; push_ready = 1'b1;
        for (int i = 0; i < 8; i++) stk[i] = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_ops", ops_done, 32'd0);
        check("rst_trap", 32'({trap_valid, trap_code}), 32'd0);
        tick();
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // ADD with cycle-accurate latency: stack [5,7], 7 on top.
        load2(32'd5, 32'd7);
        cmd_op = ALU_ADD; cmd_valid = 1'b1;
        tick(); cmd_valid = 1'b0;                         // c1
        check("c1_pop_req", 32'(pop_req), 32'd1);
        check("c1_ready", 32'(cmd_ready), 32'd0);
        tick();                                           // c2
        tick();                                           // c3
        check("c3_alu_valid", 32'(alu_valid), 32'd1);
        check("c3_alu_a", alu_a, 32'd5);
        check("c3_alu_b", alu_b, 32'd7);
        tick();                                           // c4
        check("c4_push_valid", 32'(push_valid), 32'd1);
        check("c4_push_data", push_data, 32'd12);
        tick();                                           // c5
        check("c5_ready", 32'(cmd_ready), 32'd1);
        check("c5_ops", ops_done, 32'd1);

        run_op("sub", ALU_SUB, 32'd10, 32'd3, 32'd2);
        check("sub_val", last_push, 32'd7);
        run_op("lts", ALU_LT_S, 32'hFFFF_FFFF, 32'd1, 32'd3);
        check("lts_val", last_push, 32'd1);

        // Unary CLZ: only the top value may be consumed.
        load2(32'd99, 32'h0001_0000);
        p0 = pop_cnt;
        issue(ALU_CLZ);
        wait_idle(40);
        tick();
        check("clz_pops", 32'(pop_cnt - p0), 32'd1);
        check("clz_alu_b", last_b, 32'd0);
        check("clz_push", last_push, 32'd15);
        check("clz_ops", ops_done, 32'd4);

        // Divide by zero traps and halts until reset.
        load2(32'd8, 32'd0);
        pc0 = push_cnt;
        issue(ALU_DIV_S);
        wait_idle(40);
        check("trap_valid", 32'(trap_valid), 32'd1);
        check("trap_code", 32'(trap_code), 32'(TRAP_INT_DIV_ZERO));
        bad = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cmd_ready || !trap_valid || push_valid || pop_req ||
                trap_code != TRAP_INT_DIV_ZERO) bad++;
        end
        cmd_valid = 1'b0;
        check("halt_sticky", 32'(bad), 32'd0);
        check("trap_no_push", 32'(push_cnt - pc0), 32'd0);
        check("trap_ops", ops_done, 32'd4);
        rst = 1'b1; tick(); rst = 1'b0;
        check("trap_rst_valid", 32'(trap_valid), 32'd0);
        check("trap_rst_code", 32'(trap_code), 32'(TRAP_NONE));
        check("trap_rst_busy", 32'(busy), 32'd0);
        tick();
        check("trap_rst_ready", 32'(cmd_ready), 32'd1);

        // Underflow on the second pop of a binary op.
        stk[0] = 32'd7; depth = 1; pop_base = pop_cnt;
        ops0 = int'(ops_done); uf0 = uf_cyc; al0 = alu_cyc;
        issue(ALU_ADD);
        wait_idle(40);
        tick();
        check("uf_pulse", 32'(uf_cyc - uf0), 32'd1);
        check("uf_no_alu", 32'(alu_cyc - al0), 32'd0);
        check("uf_ops", ops_done, 32'(ops0));

        // ALU never answers: timeout after 16 issue cycles.
        alu_en = 1'b0;
        load2(32'd1, 32'd2);
        to0 = to_cyc; al0 = alu_cyc; pc0 = push_cnt;
        issue(ALU_ADD);
        wait_idle(60);
        tick();
        alu_en = 1'b1;
        check("to_pulse", 32'(to_cyc - to0), 32'd1);
        check("to_alu_cycles", 32'(alu_cyc - al0), 32'd16);
        check("to_no_push", 32'(push_cnt - pc0), 32'd0);

        // Push back-pressure for three cycles.
        push_ready = 1'b0;
        load2(32'd2, 32'd3);
        issue(ALU_ADD);
        n = 0;
        while (!push_valid && n < 20) begin tick(); n++; end
        check("bp_push_seen", 32'(push_valid), 32'd1);
        ops0 = int'(ops_done);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (!push_valid || push_data != 32'd5 || ops_done != 32'(ops0)) bad++;
            if (i < 2) tick();
        end
        check("bp_stable", 32'(bad), 32'd0);
        push_ready = 1'b1;
        tick();
        check("bp_done_valid", 32'(push_valid), 32'd0);
        check("bp_ops", ops_done, 32'(ops0 + 1));

        // Reset while waiting in EXEC.
        alu_en = 1'b0;
        load2(32'd4, 32'd6);
        issue(ALU_ADD);
        n = 0;
        while (!alu_valid && n < 10) begin tick(); n++; end
        check("rx_exec_seen", 32'(alu_valid), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        alu_en = 1'b1;
        check("rx_outputs_zero", 32'(|{cmd_ready, pop_req, push_valid, push_data, alu_valid,
              alu_op, alu_a, alu_b, trap_valid, trap_code, err_underflow, err_timeout,
              busy, ops_done}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
